// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings, response FSM states and byte-lane decode for the SRAM responder.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_state_e;

  // Little-endian lanes; sizes above word decode as word and low bits are aligned down.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_ctrl_wbuf.sv
// One-entry write buffer: allocate on address, fill on data, retire when the port is free,
// and overlay its bytes onto SRAM read data for a matching word.
module ahb_sram_wbuf #(
  parameter int unsigned WAW = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alloc,
  input  logic [WAW-1:0] alloc_addr,
  input  logic [3:0]     alloc_mask,
  input  logic [31:0]    wdata,
  input  logic           port_busy,
  input  logic [WAW-1:0] rd_addr,
  input  logic [31:0]    sram_rdata,
  output logic [31:0]    merged_rdata,
  output logic           ret_en,
  output logic [WAW-1:0] ret_addr,
  output logic [3:0]     ret_mask,
  output logic [31:0]    ret_data
);

  logic           pend;
  logic           valid;
  logic [WAW-1:0] addr;
  logic [3:0]     mask;
  logic [31:0]    data;
  logic           ret_reg;
  logic           ret_fly;

  // A pending entry displaced by a new allocation retires straight from the data bus.
  assign ret_reg  = valid & ~port_busy;
  assign ret_fly  = pend & alloc;
  assign ret_en   = ret_reg | ret_fly;
  assign ret_addr = addr;
  assign ret_mask = mask;
  assign ret_data = pend ? wdata : data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      valid <= 1'b0;
      addr  <= '0;
      mask  <= '0;
      data  <= '0;
    end else if (alloc) begin
      addr  <= alloc_addr;
      mask  <= alloc_mask;
      pend  <= 1'b1;
      valid <= 1'b0;
    end else if (pend) begin
      data  <= wdata;
      pend  <= 1'b0;
      valid <= 1'b1;
    end else if (ret_reg) begin
      valid <= 1'b0;
    end
  end

  always_comb begin
    merged_rdata = sram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (valid && (addr == rd_addr) && mask[b]) begin
        merged_rdata[8*b +: 8] = data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave_ctrl.sv
// Zero-wait AHB-Lite responder for a single-port synchronous SRAM with a one-entry write buffer.
// Define AHB_SRAM_ERR_RESP_EN to answer illegal/out-of-range accesses with a two-cycle ERROR.
module ahb_sram_slave_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned AW          = 16,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA
);

  resp_state_e state, state_nxt;
  logic          access, illegal, legal, rd_ap, wr_ap;
  logic          ready_c, resp_c;
  logic [AW-3:0] waddr;
  logic [3:0]    amask;
  logic          rd_dp;
  logic [AW-3:0] rd_waddr;
  logic [31:0]   merged;
  logic          ret_en;
  logic [AW-3:0] ret_addr;
  logic [3:0]    ret_mask;
  logic [31:0]   ret_data;
  logic          unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:AW], 32'(MEM_BYTES)};

  assign access = HSEL & HREADY & HTRANS[1];
`ifdef AHB_SRAM_ERR_RESP_EN
  assign illegal = (HSIZE > HSIZE_WORD)
                 || ((HSIZE == HSIZE_HALF) && HADDR[0])
                 || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                 || (HADDR[31:AW] != '0);
`else
  assign illegal = 1'b0;
`endif
  assign legal = access & ~illegal;
  assign rd_ap = legal & ~HWRITE;
  assign wr_ap = legal & HWRITE;
  assign waddr = HADDR[AW-1:2];
  assign amask = lane_mask(HSIZE, HADDR[1:0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= OKAY;
    else          state <= state_nxt;
  end

  // Response sequencing: OKAY, or ERR1 (wait) followed by ERR2 (complete).
  always_comb begin
    state_nxt = OKAY;
    ready_c   = 1'b1;
    resp_c    = HRESP_OKAY;
    case (state)
      OKAY: if (access && illegal) state_nxt = ERR1;
      ERR1: begin
        ready_c   = 1'b0;
        resp_c    = HRESP_ERROR;
        state_nxt = ERR2;
      end
      ERR2: begin
        resp_c = HRESP_ERROR;
        if (access && illegal) state_nxt = ERR1;
      end
      default: state_nxt = OKAY;
    endcase
  end

  assign HREADYOUT = ready_c;
  assign HRESP     = resp_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_dp    <= 1'b0;
      rd_waddr <= '0;
    end else begin
      rd_dp <= rd_ap;
      if (rd_ap) rd_waddr <= waddr;
    end
  end

  ahb_sram_wbuf #(.WAW(AW - 2)) u_wbuf (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .alloc        (wr_ap),
    .alloc_addr   (waddr),
    .alloc_mask   (amask),
    .wdata        (HWDATA),
    .port_busy    (rd_ap),
    .rd_addr      (rd_waddr),
    .sram_rdata   (SRAMRDATA),
    .merged_rdata (merged),
    .ret_en       (ret_en),
    .ret_addr     (ret_addr),
    .ret_mask     (ret_mask),
    .ret_data     (ret_data)
  );

  // A read address phase owns the port; otherwise the buffer may retire.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMADDR  = ret_addr;
    SRAMWEN   = 4'b0000;
    SRAMWDATA = ret_data;
    if (rd_ap) begin
      SRAMCS   = 1'b1;
      SRAMADDR = waddr;
    end else if (ret_en) begin
      SRAMCS  = 1'b1;
      SRAMWEN = ret_mask;
    end
  end

  assign HRDATA = rd_dp ? merged : RESET_RDATA;

endmodule

// File: tb/tb_ahb_sram_slave_ctrl.sv
// Directed vector bench for ahb_sram_slave_ctrl with a behavioural SRAM macro model.
module tb_ahb_sram_slave_ctrl;
  import ahb_sram_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [13:0] SRAMADDR;
  logic        SRAMCS;
  logic [3:0]  SRAMWEN;
  logic [31:0] SRAMWDATA;
  logic [31:0] SRAMRDATA;

  int n_vec = 0;
  int n_mis = 0;

  ahb_sram_slave_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMADDR(SRAMADDR),
    .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMRDATA(SRAMRDATA)
  );

  // Single-slave bus: bus-level ready is the slave's own ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // SRAM macro model: reads return data the cycle after chip select.
  bit [31:0] mem [int];
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'h0) begin
        SRAMRDATA <= mem.exists(int'(SRAMADDR)) ? mem[int'(SRAMADDR)] : 32'h0;
      end else begin
        bit [31:0] w;
        w = mem.exists(int'(SRAMADDR)) ? mem[int'(SRAMADDR)] : 32'h0;
        for (int b = 0; b < 4; b++) if (SRAMWEN[b]) w[8*b +: 8] = SRAMWDATA[8*b +: 8];
        mem[int'(SRAMADDR)] = w;
      end
    end
  end

  logic mon_en = 1'b0;
  int   wen_hits = 0;
  always @(negedge HCLK) begin
    if (mon_en && SRAMCS && (SRAMWEN != 4'h0) && (SRAMADDR == 14'h100)) wen_hits++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        cs;
    logic [3:0]  wen;
    logic [13:0] saddr;
    logic [31:0] swdata;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                              input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                              input logic chk, input logic [31:0] rd, input logic cs,
                              input logic [3:0] wen, input logic [13:0] sa, input logic [31:0] sw);
    vec_t v;
    v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = addr; v.wdata = wd;
    v.chk_rd = chk; v.rdata = rd; v.cs = cs; v.wen = wen; v.saddr = sa; v.swdata = sw;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd);
    @(posedge HCLK);
    #1;
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = addr; HWDATA = wd;
    @(negedge HCLK);
  endtask

  task automatic idle(input logic [31:0] wd);
    bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0, wd);
  endtask

  initial begin
    // sel tr wr sz addr wdata | chk_rd rdata | cs wen saddr swdata
    vt[0]  = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[1]  = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0,    32'h0,        1, 32'h0,        1, 4'h0, 14'h0,    32'h0);
    vt[2]  = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[3]  = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h100,  32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[4]  = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h100,  32'hDEADBEEF, 1, 32'h0,        1, 4'h0, 14'h040,  32'h0);
    vt[5]  = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'hDEADBEEF, 1, 4'hF, 14'h040,  32'hDEADBEEF);
    vt[6]  = mk(1, HTRANS_BUSY,   0, HSIZE_WORD, 32'h100,  32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[7]  = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h200,  32'h0,        0, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[8]  = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h11223344, 1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[9]  = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'h0,        1, 4'hF, 14'h080,  32'h11223344);
    vt[10] = mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h203,  32'h0,        0, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[11] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'hAA000000, 0, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[12] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        0, 32'h0,        1, 4'h8, 14'h080,  32'hAA000000);
    vt[13] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h200,  32'h0,        0, 32'h0,        1, 4'h0, 14'h080,  32'h0);
    vt[14] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'hAA223344, 0, 4'h0, 14'h0,    32'h0);
    vt[15] = mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h200,  32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[16] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h200,  32'h00005566, 1, 32'h0,        1, 4'h0, 14'h080,  32'h0);
    vt[17] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'hAA225566, 1, 4'h3, 14'h080,  32'h00005566);
    vt[18] = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h300,  32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[19] = mk(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h304,  32'h1,        1, 32'h0,        1, 4'hF, 14'h0C0,  32'h1);
    vt[20] = mk(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h308,  32'h2,        1, 32'h0,        1, 4'hF, 14'h0C1,  32'h2);
    vt[21] = mk(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h30C,  32'h3,        1, 32'h0,        1, 4'hF, 14'h0C2,  32'h3);
    vt[22] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h300,  32'h4,        1, 32'h0,        1, 4'h0, 14'h0C0,  32'h0);
    vt[23] = mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h304,  32'h0,        1, 32'h1,        1, 4'h0, 14'h0C1,  32'h0);
    vt[24] = mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h308,  32'h0,        1, 32'h2,        1, 4'h0, 14'h0C2,  32'h0);
    vt[25] = mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h30C,  32'h0,        1, 32'h3,        1, 4'h0, 14'h0C3,  32'h0);
    vt[26] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'h4,        1, 4'hF, 14'h0C3,  32'h4);
    vt[27] = mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'hFFFC, 32'h0,        1, 32'h0,        0, 4'h0, 14'h0,    32'h0);
    vt[28] = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'hFFFC, 32'hCAFEF00D, 1, 32'h0,        1, 4'h0, 14'h3FFF, 32'h0);
    vt[29] = mk(0, HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,    32'h0,        1, 32'hCAFEF00D, 1, 4'hF, 14'h3FFF, 32'hCAFEF00D);

    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HSIZE = HSIZE_BYTE; HBURST = 3'd0; HWDATA = 32'h0;

    // Reset values
    repeat (2) @(negedge HCLK);
    cmp("rst_hreadyout", 0, 32'(HREADYOUT), 32'h1);
    cmp("rst_hresp",     0, 32'(HRESP),     32'h0);
    cmp("rst_hrdata",    0, HRDATA,         32'h0);
    cmp("rst_sramcs",    0, 32'(SRAMCS),    32'h0);
    cmp("rst_sramwen",   0, 32'(SRAMWEN),   32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus(vt[i].sel, vt[i].tr, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wdata);
      cmp("hreadyout", i, 32'(HREADYOUT), 32'h1);
      cmp("hresp",     i, 32'(HRESP),     32'h0);
      cmp("sramcs",    i, 32'(SRAMCS),    32'(vt[i].cs));
      cmp("sramwen",   i, 32'(SRAMWEN),   32'(vt[i].wen));
      if (vt[i].chk_rd)        cmp("hrdata",    i, HRDATA,          vt[i].rdata);
      if (vt[i].cs)            cmp("sramaddr",  i, 32'(SRAMADDR),   32'(vt[i].saddr));
      if (vt[i].wen != 4'h0)   cmp("sramwdata", i, SRAMWDATA,       vt[i].swdata);
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    // Out-of-range access: two-cycle ERROR, no SRAM activity
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0001_0000, 32'h0);
    cmp("err_ap_cs",    0, 32'(SRAMCS),    32'h0);
    cmp("err_ap_ready", 0, 32'(HREADYOUT), 32'h1);
    idle(32'h0);
    cmp("err1_ready",   0, 32'(HREADYOUT), 32'h0);
    cmp("err1_resp",    0, 32'(HRESP),     32'h1);
    cmp("err1_cs",      0, 32'(SRAMCS),    32'h0);
    idle(32'h0);
    cmp("err2_ready",   0, 32'(HREADYOUT), 32'h1);
    cmp("err2_resp",    0, 32'(HRESP),     32'h1);
    cmp("err2_cs",      0, 32'(SRAMCS),    32'h0);
    idle(32'h0);
    cmp("err_done_resp", 0, 32'(HRESP),    32'h0);
`else
    // Out-of-range write aliases onto word 0
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0001_0000, 32'h0);
    idle(32'h12345678);
    idle(32'h0);
    cmp("alias_wen",   0, 32'(SRAMWEN),  32'hF);
    cmp("alias_saddr", 0, 32'(SRAMADDR), 32'h0);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0000, 32'h0);
    idle(32'h0);
    cmp("alias_rd",    0, HRDATA,        32'h12345678);
    cmp("alias_resp",  0, 32'(HRESP),    32'h0);
`endif

    // Reset after a write data phase discards the buffered entry
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h400, 32'h0);
    idle(32'h01020304);
    idle(32'h0);
    idle(32'h0);
    mon_en = 1'b1;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h400, 32'h0);
    cmp("rstw_ap_cs", 0, 32'(SRAMCS), 32'h0);
    idle(32'hFFFFFFFF);
    cmp("rstw_dp_cs", 0, 32'(SRAMCS), 32'h0);
    @(posedge HCLK);
    HRESETn = 1'b0;
    #1 HWDATA = 32'h0;
    @(negedge HCLK);
    cmp("rstw_wen",    0, 32'(SRAMWEN), 32'h0);
    cmp("rstw_hrdata", 0, HRDATA,       32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(32'h0);
    cmp("rstw_idle_cs", 0, 32'(SRAMCS), 32'h0);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h400, 32'h0);
    cmp("rstw_rd_cs", 0, 32'(SRAMCS), 32'h1);
    idle(32'h0);
    cmp("rstw_rd", 0, HRDATA, 32'h01020304);
    idle(32'h0);
    mon_en = 1'b0;
    cmp("rstw_wen_hits", 0, 32'(wen_hits), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
